fpga_config_loader: RTL and testbench

//  Serial configuration loader for fpga_top: receives a framed bitstream over a valid/ready
//  bit interface, checks it with CRC-8, and drives every select bus of the fabric
//  (brbselect, bsbselect, lbselect, four IO selects). Writer side of the fabric's select inputs.

---
 rtl/fpga_config_loader_if.sv | 20 ++
 rtl/fpga_config_loader.sv | 155 +++++++++++++++
 tb/tb_fpga_config_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fpga_config_loader_if.sv
// Serial configuration bit stream between a configuration source and the fabric loader.
// A bit transfers on a rising clk edge where cfg_valid && cfg_ready. The source holds cfg_bit
// steady while cfg_valid is high and not yet accepted. cfg_ready does not depend on cfg_valid.
interface fpga_config_loader_if;
  logic cfg_bit;
  logic cfg_valid;
  logic cfg_ready;

  modport master (
    output cfg_bit,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_bit,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/fpga_config_loader.sv
// Framed serial configuration loader: hunts for a sync word, shifts a CRC-8 protected bitstream
// into a shadow register and commits it to the fabric select buses only when the CRC matches.
module fpga_config_loader #(
  parameter int          BRB_BITS  = 750,
  parameter int          BSB_BITS  = 1728,
  parameter int          LB_BITS   = 80,
  parameter int          IO_BITS   = 20,
  parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fpga_config_loader_if.slave  cfg,
  output logic                 cfg_done,
  output logic                 cfg_error,
  output logic                 fabric_en,
  output logic [BRB_BITS-1:0]  brbselect,
  output logic [BSB_BITS-1:0]  bsbselect,
  output logic [LB_BITS-1:0]   lbselect,
  output logic [IO_BITS-1:0]   leftioselect,
  output logic [IO_BITS-1:0]   rightioselect,
  output logic [IO_BITS-1:0]   topioselect,
  output logic [IO_BITS-1:0]   bottomioselect,
  output logic [1:0]           dbg_state_o
);

  localparam int          CFG_BITS  = BRB_BITS + BSB_BITS + LB_BITS + 4 * IO_BITS;
  localparam logic [11:0] LAST_DATA = 12'(CFG_BITS - 1);
  localparam logic [11:0] LAST_CRC  = 12'd7;

  localparam logic [1:0] HUNT  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] CRCRX = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;

  logic [1:0]          state_q,  state_d;
  logic [7:0]          win_q,    win_d;
  logic [11:0]         cnt_q,    cnt_d;
  logic [7:0]          crc_q,    crc_d;
  logic [7:0]          rx_crc_q, rx_crc_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] sel_q,    sel_d;
  logic                done_q,   done_d;
  logic                err_q,    err_d;
  logic                en_q,     en_d;

  logic       accept;
  logic       crc_fb;
  logic [7:0] crc_step;

  assign cfg.cfg_ready = (state_q != CHECK);
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;

  // CRC-8 poly 0x07, MSB-first, one data bit per accept.
  assign crc_fb   = crc_q[7] ^ cfg.cfg_bit;
  assign crc_step = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    rx_crc_d = rx_crc_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;
    done_d   = done_q;
    err_d    = err_q;
    en_d     = en_q;
    case (state_q)
      HUNT: begin
        if (accept) begin
          win_d = {win_q[6:0], cfg.cfg_bit};
          if ({win_q[6:0], cfg.cfg_bit} == SYNC_WORD) begin
            state_d = LOAD;
            done_d  = 1'b0;
            err_d   = 1'b0;
            en_d    = 1'b0;
            cnt_d   = '0;
            crc_d   = '0;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          shadow_d = {shadow_q[CFG_BITS-2:0], cfg.cfg_bit};
          crc_d    = crc_step;
          if (cnt_q == LAST_DATA) begin
            state_d = CRCRX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      CRCRX: begin
        if (accept) begin
          rx_crc_d = {rx_crc_q[6:0], cfg.cfg_bit};
          if (cnt_q == LAST_CRC) begin
            state_d = CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      CHECK: begin
        // A failed frame leaves the previously committed selects untouched.
        if (rx_crc_q == crc_q) begin
          sel_d  = shadow_q;
          done_d = 1'b1;
          en_d   = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
        state_d = HUNT;
        win_d   = '0;
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      win_q    <= '0;
      cnt_q    <= '0;
      crc_q    <= '0;
      rx_crc_q <= '0;
      shadow_q <= '0;
      sel_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      rx_crc_q <= rx_crc_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
      err_q    <= err_d;
      en_q     <= en_d;
    end
  end

  assign {brbselect, bsbselect, lbselect, leftioselect,
          rightioselect, topioselect, bottomioselect} = sel_q;

  assign cfg_done    = done_q;
  assign cfg_error   = err_q;
  assign fabric_en   = en_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Directed bench for fpga_config_loader: full frames with good and bad CRC, noise before sync,
// random valid gaps and an asynchronous reset in the middle of a frame.
module tb_fpga_config_loader;

  localparam int         BRB_BITS = 750;
  localparam int         BSB_BITS = 1728;
  localparam int         LB_BITS  = 80;
  localparam int         IO_BITS  = 20;
  localparam int         CFG_BITS = BRB_BITS + BSB_BITS + LB_BITS + 4 * IO_BITS;
  localparam logic [7:0] SYNC     = 8'hA5;

  logic clk;
  logic rst_n;
  logic cfg_done;
  logic cfg_error;
  logic fabric_en;
  logic [BRB_BITS-1:0] brbselect;
  logic [BSB_BITS-1:0] bsbselect;
  logic [LB_BITS-1:0]  lbselect;
  logic [IO_BITS-1:0]  leftioselect;
  logic [IO_BITS-1:0]  rightioselect;
  logic [IO_BITS-1:0]  topioselect;
  logic [IO_BITS-1:0]  bottomioselect;
  logic [1:0]          dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  fpga_config_loader_if cfg_if ();

  fpga_config_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg            (cfg_if.slave),
    .cfg_done       (cfg_done),
    .cfg_error      (cfg_error),
    .fabric_en      (fabric_en),
    .brbselect      (brbselect),
    .bsbselect      (bsbselect),
    .lbselect       (lbselect),
    .leftioselect   (leftioselect),
    .rightioselect  (rightioselect),
    .topioselect    (topioselect),
    .bottomioselect (bottomioselect),
    .dbg_state_o    (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: called and returning on a falling edge.
  task automatic send_bit(input logic b, input bit gaps);
    int waited;
    int g;
    if (gaps) begin
      g = $urandom_range(0, 2);
      cfg_if.cfg_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
    cfg_if.cfg_bit   = b;
    cfg_if.cfg_valid = 1'b1;
    waited = 0;
    while (cfg_if.cfg_ready !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (cfg_if.cfg_ready !== 1'b1) check("ready_timeout", {31'd0, cfg_if.cfg_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gaps);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gaps);
  endtask

  task automatic send_frame(input logic last_bit, input logic [7:0] crc, input bit gaps);
    send_byte(SYNC, gaps);
    for (int i = 0; i < CFG_BITS - 1; i++) send_bit(1'b0, gaps);
    send_bit(last_bit, gaps);
    send_byte(crc, gaps);
    cfg_if.cfg_valid = 1'b0;
  endtask

  // Right after the last CRC accept: CHECK cycle, nothing committed yet.
  task automatic check_in_check(input string tag, input logic prev_bottom);
    check({tag, "_ready_low"}, {31'd0, cfg_if.cfg_ready}, 32'd0);
    check({tag, "_done_pre"},  {31'd0, cfg_done},         32'd0);
    check({tag, "_bottom_pre"}, {12'd0, bottomioselect},  {12'd0, 19'd0, prev_bottom});
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic done, input logic err,
                            input logic en, input logic [IO_BITS-1:0] bottom);
    check({tag, "_done"},   {31'd0, cfg_done},        {31'd0, done});
    check({tag, "_error"},  {31'd0, cfg_error},       {31'd0, err});
    check({tag, "_en"},     {31'd0, fabric_en},       {31'd0, en});
    check({tag, "_ready"},  {31'd0, cfg_if.cfg_ready}, 32'd1);
    check({tag, "_bottom"}, {12'd0, bottomioselect},  {12'd0, bottom});
    check({tag, "_others"},
          {31'd0, |{brbselect, bsbselect, lbselect, leftioselect, rightioselect, topioselect}},
          32'd0);
  endtask

  initial begin
    rst_n            = 1'b0;
    cfg_if.cfg_bit   = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset values
    check_outs("reset", 1'b0, 1'b0, 1'b0, 20'h0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2: all-zero frame, CRC 0x00
    send_frame(1'b0, 8'h00, 1'b0);
    check_in_check("zero", 1'b0);
    check_outs("zero", 1'b1, 1'b0, 1'b1, 20'h0);

    // 3: last data bit set lands in bottomioselect[0]; CRC of that stream is 0x07
    send_frame(1'b1, 8'h07, 1'b0);
    check_in_check("one", 1'b0);
    check_outs("one", 1'b1, 1'b0, 1'b1, 20'h00001);

    // 4: same data, wrong CRC: error, previous selects kept
    send_frame(1'b1, 8'h00, 1'b0);
    check_in_check("badcrc", 1'b1);
    check_outs("badcrc", 1'b0, 1'b1, 1'b0, 20'h00001);

    // 5: noise then frame with random gaps. 8'h52 followed by a 1 would itself
    // complete the sync word, so one 0 bit separates the noise from the frame.
    send_byte(8'hFF, 1'b1);
    send_byte(8'h52, 1'b1);
    send_bit(1'b0, 1'b1);
    check("noise_state", {30'd0, dbg_state}, 32'd0);
    check("noise_error_kept", {31'd0, cfg_error}, 32'd1);
    send_frame(1'b1, 8'h07, 1'b1);
    check_in_check("gaps", 1'b1);
    check_outs("gaps", 1'b1, 1'b0, 1'b1, 20'h00001);

    // 6: asynchronous reset after 1000 data bits
    send_byte(SYNC, 1'b0);
    for (int i = 0; i < 1000; i++) send_bit(1'b0, 1'b0);
    cfg_if.cfg_valid = 1'b0;
    check("midframe_state", {30'd0, dbg_state}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 1'b0, 20'h0);
    check("async_rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(1'b1, 8'h07, 1'b0);
    check_in_check("after_rst", 1'b0);
    check_outs("after_rst", 1'b1, 1'b0, 1'b1, 20'h00001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
